// File: rtl/pipe_pkg.sv
// Shared definitions for valid/ready pipeline stage registers.
package pipe_pkg;

    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid entry for pipe_stage_reg: one payload register plus its valid flag.
module pipe_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall and synchronous flush.
// Build with PIPE_SKID_EN for a 2-entry skid version whose in_ready is registered.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RST_VAL   = '0,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_state_e        state_q, state_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign out_data  = out_q;
    assign occupancy = occ_t'(state_q);

`ifdef PIPE_SKID_EN
    logic              in_ready_q, in_ready_d;
    logic              skid_load, skid_unload, skid_vld;
    logic [DATA_W-1:0] skid_data;

    pipe_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .data_i   (in_data),
        .data_o   (skid_data),
        .valid_o  (skid_vld)
    );

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid | out_ready;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifdef PIPE_SKID_EN
        skid_load   = 1'b0;
        skid_unload = 1'b0;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            out_d   = FLUSH_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        out_d   = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_d = in_data;
`ifdef PIPE_SKID_EN
                    end else if (in_xfer) begin
                        // downstream stalled: park the new payload in the skid entry
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
`endif
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
`ifdef PIPE_SKID_EN
                ST_TWO: begin
                    if (out_xfer && skid_vld) begin
                        out_d       = skid_data;
                        skid_unload = 1'b1;
                        state_d     = ST_ONE;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
`ifdef PIPE_SKID_EN
        in_ready_d = (state_d != ST_TWO);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= RST_VAL;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

`ifdef PIPE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= in_ready_d;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (either PIPE_SKID_EN setting).
module tb_pipe_stage_reg;

    localparam logic [7:0] RST_V   = 8'hA5;
    localparam logic [7:0] FLUSH_V = 8'h13;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(8), .RST_VAL(RST_V), .FLUSH_VAL(FLUSH_V)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ordered list of held payloads plus the value shown on out_data.
    logic [7:0] mq[$];
    logic [7:0] m_data;
    logic [7:0] src[$];
    logic [7:0] seen[$];
    bit         last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
        chk("out_data", {24'd0, out_data}, {24'd0, m_data});
        chk("occupancy", {30'd0, occupancy}, mq.size());
    endtask

    task automatic step(input bit fl, input bit iv, input logic [7:0] id, input bit ordy);
        bit m_ir, ixf, oxf;
        @(negedge clk);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        m_ir = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ir});
        ixf = iv && m_ir;
        oxf = (mq.size() > 0) && ordy;
        last_acc = ixf;
        if (out_valid && ordy) seen.push_back(out_data);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_data = FLUSH_V;
        end else begin
            if (oxf) void'(mq.pop_front());
            if (ixf) mq.push_back(id);
            if (mq.size() > 0) m_data = mq[0];
        end
        #1;
        chk_model();
    endtask

    task automatic src_step(input bit fl, input bit ordy);
        bit iv;
        logic [7:0] id;
        iv = src.size() > 0;
        id = iv ? src[0] : 8'h00;
        step(fl, iv, id, ordy);
        if (last_acc) void'(src.pop_front());
    endtask

    typedef struct {
        bit         fl, iv;
        logic [7:0] id;
        bit         ordy;
        bit         e_vld;
        logic [7:0] e_data;
        logic [1:0] e_occ;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{0, 1, 8'h11, 1, 1, 8'h11, 2'd1};
        vecs[1]  = '{0, 1, 8'h22, 1, 1, 8'h22, 2'd1};
        vecs[2]  = '{0, 1, 8'h33, 1, 1, 8'h33, 2'd1};
        vecs[3]  = '{0, 0, 8'h00, 1, 0, 8'h33, 2'd0};
        vecs[4]  = '{0, 1, 8'h55, 0, 1, 8'h55, 2'd1};
        vecs[5]  = '{0, 1, 8'h66, 1, 1, 8'h66, 2'd1};
        vecs[6]  = '{1, 1, 8'h77, 1, 0, FLUSH_V, 2'd0};
        vecs[7]  = '{0, 0, 8'hDE, 1, 0, FLUSH_V, 2'd0};
        vecs[8]  = '{0, 1, 8'h88, 0, 1, 8'h88, 2'd1};
        vecs[9]  = '{0, 0, 8'h99, 0, 1, 8'h88, 2'd1};
        vecs[10] = '{0, 0, 8'h00, 1, 0, 8'h88, 2'd0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        m_data = RST_V;
        #12;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_data", {24'd0, out_data}, {24'd0, RST_V});
        chk("rst_occ", {30'd0, occupancy}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk); rst = 1'b0;

        // directed table
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk("vec_valid", {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
            chk("vec_data", {24'd0, out_data}, {24'd0, vecs[i].e_data});
            chk("vec_occ", {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
        end

        // stall three cycles, then release and expect in-order delivery
        src = '{8'h11, 8'h22, 8'h33};
        seen.delete();
        for (int i = 0; i < 3; i++) src_step(0, 0);
        chk("stall_data", {24'd0, out_data}, 32'h11);
        chk("stall_occ", {30'd0, occupancy}, SKID ? 2 : 1);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        for (int i = 0; i < 6; i++) src_step(0, 1);
        chk("stall_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("stall_ord0", {24'd0, seen[0]}, 32'h11);
            chk("stall_ord1", {24'd0, seen[1]}, 32'h22);
            chk("stall_ord2", {24'd0, seen[2]}, 32'h33);
        end

        // flush while full with an incoming payload
        src = '{8'h01, 8'h02};
        for (int i = 0; i < 2; i++) src_step(0, 0);
        src.delete();
        step(1, 1, 8'h44, 0);
        chk("flush_valid", {31'd0, out_valid}, 0);
        chk("flush_data", {24'd0, out_data}, {24'd0, FLUSH_V});
        chk("flush_in_ready", {31'd0, in_ready}, 1);
        seen.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
        chk("flush_no_leak", seen.size(), 0);

        // asynchronous reset while full
        src = '{8'hA1, 8'hA2};
        for (int i = 0; i < 2; i++) src_step(0, 0);
        src.delete();
        @(negedge clk); in_valid = 1'b0; #2; rst = 1'b1; #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_data", {24'd0, out_data}, {24'd0, RST_V});
        chk("mid_rst_occ", {30'd0, occupancy}, 0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        mq.delete();
        m_data = RST_V;
        @(negedge clk); rst = 1'b0;

        // random traffic against the reference
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom), $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
